id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-select stage directly upstream of the ALU.

---
 rtl/id_ex_stage_pkg.sv | 45 ++++
 rtl/id_ex_stage_fwd_mux.sv | 44 ++++
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared types for the ID/EX operand-select stage. Holds the
//               ALU opcode enum and the operand A/B source selects.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    // Default datapath geometry
    localparam int unsigned c_XLEN   = 32;
    localparam int unsigned c_REG_AW = 5;

    // ALU operation. OP_ADD is the bubble op because it can never raise
    // the ALU illegal-op exception.
    typedef enum logic [3:0] {
        OP_ADD     = 4'h0,
        OP_SUB     = 4'h1,
        OP_SLL     = 4'h2,
        OP_SLT     = 4'h3,
        OP_SLTU    = 4'h4,
        OP_XOR     = 4'h5,
        OP_SRL     = 4'h6,
        OP_SRA     = 4'h7,
        OP_OR      = 4'h8,
        OP_AND     = 4'h9,
        OP_PASSB   = 4'hA,
        OP_INVALID = 4'hF
    } alu_op_t;

    // Operand A source; encoding 2'b11 is unused and reads as zero
    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_ZERO = 2'b10
    } opa_sel_t;

    // Operand B source
    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_t;

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_fwd_mux
// Description : Bypass selector for one source operand. MEM has priority
//               over WB; register x0 never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = c_XLEN,
    parameter int unsigned REG_AW = c_REG_AW
) (
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_held_data,
    input  logic              i_mem_rd_we,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]   i_mem_rd_data,
    input  logic              i_wb_rd_we,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]   i_wb_rd_data,
    output logic [XLEN-1:0]   o_fwd_data
);

    logic w_rs_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_rs_nonzero = |i_rs_addr;
    assign w_mem_hit    = w_rs_nonzero && i_mem_rd_we && (i_mem_rd_addr == i_rs_addr);
    assign w_wb_hit     = w_rs_nonzero && i_wb_rd_we  && (i_wb_rd_addr  == i_rs_addr);

    // Youngest producer wins: MEM, then WB, then the captured regfile value
    always_comb begin
        o_fwd_data = i_held_data;
        if (w_mem_hit) begin
            o_fwd_data = i_mem_rd_data;
        end else if (w_wb_hit) begin
            o_fwd_data = i_wb_rd_data;
        end
    end

endmodule : id_ex_stage_fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Single-entry ID/EX pipeline register with MEM/WB operand
//               forwarding and ALU operand selection. Valid/ready on both
//               sides; flush kills the held and any incoming instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = c_XLEN,
    parameter int unsigned REG_AW = c_REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // decode side
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [1:0]        i_id_a_sel,
    input  logic              i_id_b_sel,
    input  logic [3:0]        i_id_alu_ctrl,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rd_we,
    // redirect
    input  logic              i_flush,
    // bypass sources
    input  logic              i_mem_rd_we,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]   i_mem_rd_data,
    input  logic              i_wb_rd_we,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]   i_wb_rd_data,
    // execute side
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [XLEN-1:0]   o_alu_a,
    output logic [XLEN-1:0]   o_alu_b,
    output logic [3:0]        o_alu_ctrl,
    output logic [XLEN-1:0]   o_ex_store_data,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [REG_AW-1:0] o_ex_rd_addr,
    output logic              o_ex_rd_we
);

    // Held instruction
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    opa_sel_t          r_a_sel;
    opb_sel_t          r_b_sel;
    alu_op_t           r_op;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_we;

    logic              w_load;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic [XLEN-1:0]   w_alu_a;
    logic [XLEN-1:0]   w_alu_b;

    // Ready does not look at i_id_valid so decode can use it to form valid
    assign o_id_ready = !r_valid || i_ex_ready;
    assign w_load     = i_id_valid && o_id_ready && !i_flush;

    id_ex_stage_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .i_rs_addr     (r_rs1_addr),
        .i_held_data   (r_rs1_data),
        .i_mem_rd_we   (i_mem_rd_we),
        .i_mem_rd_addr (i_mem_rd_addr),
        .i_mem_rd_data (i_mem_rd_data),
        .i_wb_rd_we    (i_wb_rd_we),
        .i_wb_rd_addr  (i_wb_rd_addr),
        .i_wb_rd_data  (i_wb_rd_data),
        .o_fwd_data    (w_fwd_rs1)
    );

    id_ex_stage_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .i_rs_addr     (r_rs2_addr),
        .i_held_data   (r_rs2_data),
        .i_mem_rd_we   (i_mem_rd_we),
        .i_mem_rd_addr (i_mem_rd_addr),
        .i_mem_rd_data (i_mem_rd_data),
        .i_wb_rd_we    (i_wb_rd_we),
        .i_wb_rd_addr  (i_wb_rd_addr),
        .i_wb_rd_data  (i_wb_rd_data),
        .o_fwd_data    (w_fwd_rs2)
    );

    // Valid/held-field update: flush beats load, load beats drain; while
    // stalled the source data tracks bypass so a retiring producer is kept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_a_sel    <= OPA_RS1;
            r_b_sel    <= OPB_RS2;
            r_op       <= OP_ADD;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_id_pc;
            r_rs1_addr <= i_id_rs1_addr;
            r_rs2_addr <= i_id_rs2_addr;
            r_rs1_data <= i_id_rs1_data;
            r_rs2_data <= i_id_rs2_data;
            r_imm      <= i_id_imm;
            r_a_sel    <= opa_sel_t'(i_id_a_sel);
            r_b_sel    <= opb_sel_t'(i_id_b_sel);
            r_op       <= alu_op_t'(i_id_alu_ctrl);
            r_rd_addr  <= i_id_rd_addr;
            r_rd_we    <= i_id_rd_we;
        end else if (r_valid && i_ex_ready) begin
            r_valid    <= 1'b0;
        end else if (r_valid) begin
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end
    end

    // Operand select from the forwarded sources, held pc and immediate
    always_comb begin
        w_alu_a = '0;
        case (r_a_sel)
            OPA_RS1:  w_alu_a = w_fwd_rs1;
            OPA_PC:   w_alu_a = r_pc;
            default:  w_alu_a = '0;
        endcase
        w_alu_b = (r_b_sel == OPB_IMM) ? r_imm : w_fwd_rs2;
    end

    assign o_ex_valid      = r_valid;
    assign o_alu_a         = w_alu_a;
    assign o_alu_b         = w_alu_b;
    assign o_alu_ctrl      = r_valid ? r_op : OP_ADD;
    assign o_ex_store_data = w_fwd_rs2;
    assign o_ex_pc         = r_pc;
    assign o_ex_rd_addr    = r_rd_addr;
    assign o_ex_rd_we      = r_rd_we && r_valid;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage with an
//               expected-result queue for accepted instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [1:0]        id_a_sel;
    logic              id_b_sel;
    logic [3:0]        id_alu_ctrl;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rd_we;
    logic              flush;
    logic              mem_rd_we;
    logic [REG_AW-1:0] mem_rd_addr;
    logic [XLEN-1:0]   mem_rd_data;
    logic              wb_rd_we;
    logic [REG_AW-1:0] wb_rd_addr;
    logic [XLEN-1:0]   wb_rd_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [3:0]        alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_rd_we;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] store;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_id_valid      (id_valid),
        .o_id_ready      (id_ready),
        .i_id_pc         (id_pc),
        .i_id_rs1_addr   (id_rs1_addr),
        .i_id_rs2_addr   (id_rs2_addr),
        .i_id_rs1_data   (id_rs1_data),
        .i_id_rs2_data   (id_rs2_data),
        .i_id_imm        (id_imm),
        .i_id_a_sel      (id_a_sel),
        .i_id_b_sel      (id_b_sel),
        .i_id_alu_ctrl   (id_alu_ctrl),
        .i_id_rd_addr    (id_rd_addr),
        .i_id_rd_we      (id_rd_we),
        .i_flush         (flush),
        .i_mem_rd_we     (mem_rd_we),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_rd_data   (mem_rd_data),
        .i_wb_rd_we      (wb_rd_we),
        .i_wb_rd_addr    (wb_rd_addr),
        .i_wb_rd_data    (wb_rd_data),
        .o_ex_valid      (ex_valid),
        .i_ex_ready      (ex_ready),
        .o_alu_a         (alu_a),
        .o_alu_b         (alu_b),
        .o_alu_ctrl      (alu_ctrl),
        .o_ex_store_data (ex_store_data),
        .o_ex_pc         (ex_pc),
        .o_ex_rd_addr    (ex_rd_addr),
        .o_ex_rd_we      (ex_rd_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction; optionally record what the ALU must see,
    // assuming no bypass source is active when it is checked
    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                         input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [1:0] asel, input logic bsel, input logic [3:0] op,
                         input logic [4:0] rd, input logic we, input logic push);
        exp_t e;
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1_addr = rs1a;
        id_rs2_addr = rs2a;
        id_rs1_data = rs1d;
        id_rs2_data = rs2d;
        id_imm      = imm;
        id_a_sel    = asel;
        id_b_sel    = bsel;
        id_alu_ctrl = op;
        id_rd_addr  = rd;
        id_rd_we    = we;
        if (push) begin
            if (asel == 2'b01)      e.a = pc;
            else if (asel == 2'b00) e.a = rs1d;
            else                    e.a = 32'h0;
            e.b     = bsel ? imm : rs2d;
            e.ctrl  = op;
            e.rd    = rd;
            e.rd_we = we;
            e.store = rs2d;
            e.pc    = pc;
            sb.push_back(e);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=pending_entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(ex_valid), 32'd1);
            chk({tag, "_a"},     alu_a,         e.a);
            chk({tag, "_b"},     alu_b,         e.b);
            chk({tag, "_ctrl"},  32'(alu_ctrl), 32'(e.ctrl));
            chk({tag, "_rd"},    32'(ex_rd_addr), 32'(e.rd));
            chk({tag, "_rdwe"},  32'(ex_rd_we), 32'(e.rd_we));
            chk({tag, "_store"}, ex_store_data, e.store);
            chk({tag, "_pc"},    ex_pc,         e.pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset held two cycles while decode offers an instruction
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        mem_rd_we = 1'b0; mem_rd_addr = '0; mem_rd_data = '0;
        wb_rd_we  = 1'b0; wb_rd_addr  = '0; wb_rd_data  = '0;
        drive(32'h40, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, OPA_RS1, OPB_IMM, OP_SUB, 5'd4, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b0; id_valid = 1'b0; #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ctrl",  32'(alu_ctrl), 32'(OP_ADD));
        chk("rst_a",     alu_a, 32'h0);
        chk("rst_b",     alu_b, 32'h0);
        chk("rst_ready", 32'(id_ready), 32'd1);
        chk("rst_rdwe",  32'(ex_rd_we), 32'd0);

        // ---- three back-to-back ADDI-style loads, no bubble
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + 32'(4*i), 5'd1, 5'd0, 32'd10 + 32'(i), 32'h0, 32'd7 + 32'(i),
                  OPA_RS1, OPB_IMM, OP_ADD, 5'd5 + 5'(i), 1'b1, 1'b1);
            tick();
            chk($sformatf("b2b%0d_ready", i), 32'(id_ready), 32'd1);
            check_out($sformatf("b2b%0d", i));
        end
        id_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(ex_valid), 32'd0);
        chk("drain_ctrl",  32'(alu_ctrl), 32'(OP_ADD));

        // ---- forwarding priority on rs1=x3
        drive(32'h200, 5'd3, 5'd4, 32'h1, 32'h2, 32'h0, OPA_RS1, OPB_RS2, OP_ADD, 5'd9, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        mem_rd_we = 1'b1; mem_rd_addr = 5'd3; mem_rd_data = 32'hAA;
        wb_rd_we  = 1'b1; wb_rd_addr  = 5'd3; wb_rd_data  = 32'hBB;
        #1;
        chk("fwd_mem_a",   alu_a, 32'hAA);
        chk("fwd_nohit_b", alu_b, 32'h2);
        mem_rd_we = 1'b0; #1;
        chk("fwd_wb_a", alu_a, 32'hBB);
        mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_rd_data = 32'hCC;
        wb_rd_we  = 1'b1; wb_rd_addr  = 5'd0; wb_rd_data  = 32'hDD;
        drive(32'h204, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, OPA_RS1, OPB_RS2, OP_ADD, 5'd10, 1'b1, 1'b0);
        tick();
        chk("fwd_x0_a", alu_a, 32'h0);
        chk("fwd_x0_b", alu_b, 32'h0);
        mem_rd_we = 1'b0; wb_rd_we = 1'b0;

        // ---- three-cycle stall; WB producer of x2 pulses only in the first
        drive(32'h300, 5'd1, 5'd2, 32'h3, 32'h11, 32'h0, OPA_RS1, OPB_RS2, OP_ADD, 5'd7, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_rd_we = 1'b1; wb_rd_addr = 5'd2; wb_rd_data = 32'h55;
        #1;
        chk("hold1_b",     alu_b, 32'h55);
        chk("hold1_store", ex_store_data, 32'h55);
        chk("hold1_ready", 32'(id_ready), 32'd0);
        tick();
        wb_rd_we = 1'b0;
        drive(32'h400, 5'd6, 5'd6, 32'h66, 32'h66, 32'h66, OPA_PC, OPB_IMM, OP_XOR, 5'd20, 1'b1, 1'b0);
        #1;
        chk("hold2_b",     alu_b, 32'h55);
        chk("hold2_store", ex_store_data, 32'h55);
        chk("hold2_ready", 32'(id_ready), 32'd0);
        tick();
        chk("hold3_b",     alu_b, 32'h55);
        chk("hold3_store", ex_store_data, 32'h55);
        chk("hold3_ready", 32'(id_ready), 32'd0);
        chk("hold3_rd",    32'(ex_rd_addr), 32'd7);
        chk("hold3_a",     alu_a, 32'h3);

        // ---- flush during hold with a new instruction offered
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0; #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rdwe",  32'(ex_rd_we), 32'd0);
        chk("flush_ctrl",  32'(alu_ctrl), 32'(OP_ADD));
        tick();
        chk("flush_nocap", 32'(ex_valid), 32'd0);

        // ---- flush also blocks a load while the stage is ready
        ex_ready = 1'b1;
        drive(32'h500, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1, OPA_RS1, OPB_RS2, OP_SUB, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_load_valid", 32'(ex_valid), 32'd0);

        // ---- AUIPC-style, then an invalid op passing through
        drive(32'h1000, 5'd0, 5'd0, 32'h0, 32'h0, 32'h2000, OPA_PC, OPB_IMM, OP_ADD, 5'd3, 1'b1, 1'b1);
        tick();
        check_out("auipc");
        drive(32'h1004, 5'd0, 5'd0, 32'h0, 32'h0, 32'h9, OPA_ZERO, OPB_IMM, OP_INVALID, 5'd0, 1'b0, 1'b1);
        tick();
        check_out("inval");
        id_valid = 1'b0;
        tick();
        chk("bubble_ctrl", 32'(alu_ctrl), 32'(OP_ADD));

        // ---- reset while an instruction is held drops it
        ex_ready = 1'b0;
        drive(32'h600, 5'd1, 5'd2, 32'h7, 32'h8, 32'h0, OPA_RS1, OPB_RS2, OP_AND, 5'd12, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        chk("midrst_pre", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        chk("midrst_rdwe",  32'(ex_rd_we), 32'd0);
        chk("midrst_a",     alu_a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
